// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT helpers: index bit reversal, log2 sizing and the default sample word.
package fft_pkg;

  localparam int SAMPLE_WIDTH = 8;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] re;
    logic [SAMPLE_WIDTH-1:0] im;
  } sample_t;

  function automatic int log2_ceil(input int n);
    return $clog2(n);
  endfunction

  // Reverses the low nbits of value; bits above nbits come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r[5'(nbits - 1 - i)] = value[5'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Streaming sample bus around the reorder stage: bit-reversed samples in, natural-order samples out.
interface fft_bitrev_reorder_if #(
  parameter int WIDTH = 8
);
  logic             enable_in;
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic             enable_out;
  logic [WIDTH-1:0] out_re;
  logic [WIDTH-1:0] out_im;

  modport master (
    output enable_in, in_re, in_im,
    input  enable_out, out_re, out_im
  );

  modport slave (
    input  enable_in, in_re, in_im,
    output enable_out, out_re, out_im
  );
endinterface

// File: rtl/fft_bitrev_reorder_ram.sv
// Simple dual-port RAM for the ping-pong frame buffer; one-cycle synchronous read, contents never reset.
module reorder_ram #(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed SDF FFT frames into natural order through a ping-pong buffer.
// First natural sample leaves two cycles after the frame's last input; frames stream back-to-back.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = 64,
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  fft_bitrev_reorder_if.slave bus
);

  localparam int LOGN = log2_ceil(N);
  localparam int AW   = LOGN + 1;

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } word_t;

  typedef enum logic {IDLE, READ} state_e;

  logic [LOGN-1:0] wcnt_q;
  logic            wbank_q;
  logic [LOGN-1:0] wcnt_rev;
  logic            frame_done;

  state_e          state_q;
  logic [LOGN-1:0] rcnt_q;
  logic            rbank_q;
  logic            rd_en;

  logic            rd_vld_q;
  logic            enable_out_q;
  logic [WIDTH-1:0] out_re_q;
  logic [WIDTH-1:0] out_im_q;
  word_t           rdata;
  word_t           wdata;

  assign wcnt_rev   = LOGN'(bit_reverse(32'(wcnt_q), LOGN));
  assign frame_done = bus.enable_in && (wcnt_q == LOGN'(N - 1));
  assign wdata      = '{re: bus.in_re, im: bus.in_im};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
    end else if (bus.enable_in) begin
      wcnt_q <= wcnt_q + LOGN'(1);
      if (frame_done) wbank_q <= ~wbank_q;
    end
  end

  // frame_done is seen in the same cycle the last word is written, so rbank
  // picks up wbank before it toggles, i.e. the bank that just filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_done) begin
            rbank_q <= wbank_q;
            rcnt_q  <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          if (rcnt_q == LOGN'(N - 1)) begin
            rcnt_q <= '0;
            if (frame_done) rbank_q <= wbank_q;
            else            state_q <= IDLE;
          end else begin
            rcnt_q <= rcnt_q + LOGN'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en = (state_q == READ);

  reorder_ram #(
    .AW (AW),
    .DW (2 * WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (bus.enable_in),
    .waddr_i ({wbank_q, wcnt_rev}),
    .wdata_i (wdata),
    .re_i    (rd_en),
    .raddr_i ({rbank_q, rcnt_q}),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q     <= 1'b0;
      enable_out_q <= 1'b0;
      out_re_q     <= '0;
      out_im_q     <= '0;
    end else begin
      rd_vld_q     <= rd_en;
      enable_out_q <= rd_vld_q;
      if (rd_vld_q) begin
        out_re_q <= rdata.re;
        out_im_q <= rdata.im;
      end
    end
  end

  assign bus.enable_out = enable_out_q;
  assign bus.out_re     = out_re_q;
  assign bus.out_im     = out_im_q;

endmodule
